// File: rtl/plc_pkg.sv
// Shared types and helpers for the parity-line-check wrapper and its suspect-line list.
package plc_pkg;

  localparam int PLC_ADDR_WIDTH = 8;
  localparam int PLC_WAY_WIDTH  = 4;
  localparam int PLC_LIST_DEPTH = 16;
  localparam int PLC_KEY_MAX    = 64;

  typedef struct packed {
    logic [PLC_WAY_WIDTH-1:0]  way;
    logic [PLC_ADDR_WIDTH-1:0] addr;
  } plc_entry_t;

  typedef enum logic [1:0] {
    SCRUB_IDLE,
    SCRUB_ISSUE,
    SCRUB_WAIT
  } scrub_state_t;

  // Keys of any width up to PLC_KEY_MAX are zero-extended by the caller before comparing.
  function automatic logic key_match(input logic [PLC_KEY_MAX-1:0] a,
                                     input logic [PLC_KEY_MAX-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/plc_list.sv
// Compacted list of suspect {way, addr} keys: insert, two-port delete with compaction, lookup.
module plc_list
  import plc_pkg::*;
#(
  parameter int KEY_W      = PLC_WAY_WIDTH + PLC_ADDR_WIDTH,
  parameter int LIST_DEPTH = PLC_LIST_DEPTH,
  localparam int CNT_W     = $clog2(LIST_DEPTH + 1),
  localparam int IDX_W     = $clog2(LIST_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_en,
  input  logic [KEY_W-1:0] ins_key,
  input  logic             del_a_en,
  input  logic [KEY_W-1:0] del_a_key,
  input  logic             del_b_en,
  input  logic [KEY_W-1:0] del_b_key,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             lookup_hit,
  output logic [CNT_W-1:0] size
);

  logic [KEY_W-1:0] list   [LIST_DEPTH];
  logic [KEY_W-1:0] list_d [LIST_DEPTH];
  logic [CNT_W-1:0] size_d;

  assign rd_key = list[rd_idx];

  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < LIST_DEPTH; i++) begin
      if ((CNT_W'(i) < size) && key_match(PLC_KEY_MAX'(list[i]), PLC_KEY_MAX'(ins_key)))
        lookup_hit = 1'b1;
    end
  end

  // Survivors are packed down in order, then a new key is appended at the new tail.
  always_comb begin
    size_d = '0;
    for (int i = 0; i < LIST_DEPTH; i++) list_d[i] = list[i];
    for (int i = 0; i < LIST_DEPTH; i++) begin
      if ((CNT_W'(i) < size) &&
          !(del_a_en && key_match(PLC_KEY_MAX'(list[i]), PLC_KEY_MAX'(del_a_key))) &&
          !(del_b_en && key_match(PLC_KEY_MAX'(list[i]), PLC_KEY_MAX'(del_b_key)))) begin
        list_d[size_d[IDX_W-1:0]] = list[i];
        size_d = size_d + CNT_W'(1);
      end
    end
    if (ins_en && (size_d < CNT_W'(LIST_DEPTH))) begin
      list_d[size_d[IDX_W-1:0]] = ins_key;
      size_d = size_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size <= '0;
      for (int i = 0; i < LIST_DEPTH; i++) list[i] <= '0;
    end else begin
      size <= size_d;
      for (int i = 0; i < LIST_DEPTH; i++) list[i] <= list_d[i];
    end
  end

endmodule

// File: rtl/plc_wrapper.sv
// Parity-line-check wrapper in front of the data-array read port.
// Define PLC_SCRUB_EN to build the idle-cycle scrub engine; otherwise outputs are plain pass-through.
module plc_wrapper
  import plc_pkg::*;
#(
  parameter int ADDR_WIDTH = PLC_ADDR_WIDTH,
  parameter int WAY_WIDTH  = PLC_WAY_WIDTH,
  parameter int DATA_SIZE  = 64,
  parameter int LIST_DEPTH = PLC_LIST_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  add_to_list,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [WAY_WIDTH-1:0]  way_in,
  input  logic                  read_enable_in,
  input  logic                  write_enable,
  input  logic [DATA_SIZE-1:0]  data,
  input  logic                  parity_err,
  output logic                  plc_error_found,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [WAY_WIDTH-1:0]  way_out,
  output logic                  read_enable_out
);

  localparam int KEY_W = WAY_WIDTH + ADDR_WIDTH;
  localparam int CNT_W = $clog2(LIST_DEPTH + 1);
  localparam int IDX_W = $clog2(LIST_DEPTH);

  logic [KEY_W-1:0]      in_key;
  logic [KEY_W-1:0]      rd_key;
  logic [IDX_W-1:0]      rd_idx;
  logic [CNT_W-1:0]      size;
  logic                  lookup_hit;
  logic                  list_full;
  logic                  ins_en;
  logic                  overflow;
  logic                  del_b_en;
  logic [KEY_W-1:0]      del_b_key;
  logic                  scrub_go;
  logic                  err_d;
  logic                  re_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [WAY_WIDTH-1:0]  way_d;
  logic                  unused_data;

  assign unused_data = ^data;
  assign in_key      = {way_in, addr_in};
  assign list_full   = (size == CNT_W'(LIST_DEPTH));

  // Add and write share one key, so a same-cycle write always cancels the add.
  assign ins_en   = add_to_list && !write_enable && !lookup_hit && !list_full;
  assign overflow = add_to_list && !write_enable && !lookup_hit && list_full;

  plc_list #(
    .KEY_W      (KEY_W),
    .LIST_DEPTH (LIST_DEPTH)
  ) PLC_List (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_en     (ins_en),
    .ins_key    (in_key),
    .del_a_en   (write_enable),
    .del_a_key  (in_key),
    .del_b_en   (del_b_en),
    .del_b_key  (del_b_key),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .lookup_hit (lookup_hit),
    .size       (size)
  );

`ifdef PLC_SCRUB_EN
  scrub_state_t     state, state_d;
  logic [IDX_W-1:0] scrub_ptr, scrub_ptr_d, ptr_eff;
  logic [CNT_W-1:0] ptr_inc;
  logic [KEY_W-1:0] scrub_key, scrub_key_d;
  logic             discard, discard_d;
  logic             result_ok;

  // The list may have shrunk since the pointer last moved; restart from the head then.
  assign ptr_eff  = (CNT_W'(scrub_ptr) < size) ? scrub_ptr : '0;
  assign ptr_inc  = CNT_W'(ptr_eff) + CNT_W'(1);
  assign rd_idx   = ptr_eff;
  assign scrub_go = (state == SCRUB_IDLE) && !read_enable_in && !write_enable && (size != '0);
  assign result_ok = (state == SCRUB_WAIT) && !discard &&
                     !(write_enable && key_match(PLC_KEY_MAX'(in_key), PLC_KEY_MAX'(scrub_key)));

  always_comb begin
    state_d     = state;
    scrub_ptr_d = scrub_ptr;
    scrub_key_d = scrub_key;
    discard_d   = discard;
    del_b_en    = 1'b0;
    del_b_key   = scrub_key;
    err_d       = overflow;
    case (state)
      SCRUB_IDLE: begin
        if (scrub_go) begin
          state_d     = SCRUB_ISSUE;
          scrub_key_d = rd_key;
          discard_d   = 1'b0;
          scrub_ptr_d = (ptr_inc >= size) ? '0 : ptr_inc[IDX_W-1:0];
        end
      end
      SCRUB_ISSUE: begin
        state_d = SCRUB_WAIT;
        if (write_enable && key_match(PLC_KEY_MAX'(in_key), PLC_KEY_MAX'(scrub_key)))
          discard_d = 1'b1;
      end
      SCRUB_WAIT: begin
        state_d = SCRUB_IDLE;
        if (result_ok) begin
          if (parity_err) err_d = 1'b1;
          else            del_b_en = 1'b1;
        end
      end
      default: state_d = SCRUB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCRUB_IDLE;
      scrub_ptr <= '0;
      scrub_key <= '0;
      discard   <= 1'b0;
    end else begin
      state     <= state_d;
      scrub_ptr <= scrub_ptr_d;
      scrub_key <= scrub_key_d;
      discard   <= discard_d;
    end
  end
`else
  logic unused_parity;

  assign unused_parity = parity_err;
  assign scrub_go      = 1'b0;
  assign rd_idx        = '0;
  assign del_b_en      = 1'b0;
  assign del_b_key     = '0;
  // Without scrubbing, a repeat add is the only way to learn a listed line failed again.
  assign err_d         = overflow || (add_to_list && !write_enable && lookup_hit);
`endif

  always_comb begin
    addr_d = addr_out;
    way_d  = way_out;
    re_d   = 1'b0;
    if (read_enable_in) begin
      addr_d = addr_in;
      way_d  = way_in;
      re_d   = 1'b1;
    end else if (scrub_go) begin
      {way_d, addr_d} = rd_key;
      re_d            = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_out        <= '0;
      way_out         <= '0;
      read_enable_out <= 1'b0;
      plc_error_found <= 1'b0;
    end else begin
      addr_out        <= addr_d;
      way_out         <= way_d;
      read_enable_out <= re_d;
      plc_error_found <= err_d;
    end
  end

endmodule

// File: tb/tb_plc_wrapper.sv
// Scoreboard bench for plc_wrapper; scrub-engine cases are built only when PLC_SCRUB_EN is defined.
module tb_plc_wrapper;
  import plc_pkg::*;

`ifdef PLC_SCRUB_EN
  localparam bit SCRUB_EN = 1'b1;
`else
  localparam bit SCRUB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        add_to_list = 1'b0;
  logic [7:0]  addr_in = '0;
  logic [3:0]  way_in = '0;
  logic        read_enable_in = 1'b0;
  logic        write_enable = 1'b0;
  logic [63:0] data = '0;
  logic        parity_err = 1'b0;
  logic        plc_error_found;
  logic [7:0]  addr_out;
  logic [3:0]  way_out;
  logic        read_enable_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       re;
    logic [7:0] addr;
    logic [3:0] way;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] held_addr = '0;
  logic [3:0] held_way = '0;

  always #5 clk = ~clk;

  plc_wrapper dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .add_to_list     (add_to_list),
    .addr_in         (addr_in),
    .way_in          (way_in),
    .read_enable_in  (read_enable_in),
    .write_enable    (write_enable),
    .data            (data),
    .parity_err      (parity_err),
    .plc_error_found (plc_error_found),
    .addr_out        (addr_out),
    .way_out         (way_out),
    .read_enable_out (read_enable_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle, pushes the expected registered outputs, then pops and compares after the edge.
  task automatic applyStimulus(input string tag, input logic add, input logic wr, input logic rd,
                               input logic [3:0] way, input logic [7:0] addr, input logic perr,
                               input logic scrub_exp, input logic [3:0] sway, input logic [7:0] saddr,
                               input logic exp_err);
    exp_t e;
    @(negedge clk);
    add_to_list    = add;
    write_enable   = wr;
    read_enable_in = rd;
    way_in         = way;
    addr_in        = addr;
    parity_err     = perr;
    data           = {$urandom, $urandom};
    e.tag = tag;
    e.err = exp_err;
    if (rd) begin
      e.re = 1'b1; held_addr = addr; held_way = way;
    end else if (scrub_exp) begin
      e.re = 1'b1; held_addr = saddr; held_way = sway;
    end else begin
      e.re = 1'b0;
    end
    e.addr = held_addr;
    e.way  = held_way;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({e.tag, ".re"},   32'(read_enable_out), 32'(e.re));
      checkOutput({e.tag, ".addr"}, 32'(addr_out),        32'(e.addr));
      checkOutput({e.tag, ".way"},  32'(way_out),         32'(e.way));
      checkOutput({e.tag, ".err"},  32'(plc_error_found), 32'(e.err));
    end
  endtask

  task automatic pipe(input string tag, input logic add, input logic wr, input logic [3:0] way,
                      input logic [7:0] addr, input logic perr, input logic exp_err);
    applyStimulus(tag, add, wr, 1'b1, way, addr, perr, 1'b0, 4'h0, 8'h00, exp_err);
  endtask

  task automatic idle(input string tag, input logic perr, input logic exp_err);
    applyStimulus(tag, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, perr, 1'b0, 4'h0, 8'h00, exp_err);
  endtask

  task automatic checkSize(input string tag, input int expected);
    checkOutput(tag, 32'(dut.PLC_List.size), 32'(expected));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.re",   32'(read_enable_out), 32'd0);
    checkOutput("rst.addr", 32'(addr_out),        32'd0);
    checkOutput("rst.way",  32'(way_out),         32'd0);
    checkOutput("rst.err",  32'(plc_error_found), 32'd0);
    checkSize("rst.size", 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Removal by write, with parity on a pipeline read ignored.
    pipe("addA", 1'b1, 1'b0, 4'h0, 8'h34, 1'b0, 1'b0);
    pipe("addB", 1'b1, 1'b0, 4'h0, 8'h55, 1'b1, 1'b0);
    checkSize("sizeAB", 2);
    pipe("wr55", 1'b0, 1'b1, 4'h0, 8'h55, 1'b0, 1'b0);
    checkSize("size_wr55", 1);
    checkOutput("list0_wr55", 32'(dut.PLC_List.list[0]), 32'h034);
    pipe("wrAA", 1'b0, 1'b1, 4'h0, 8'hAA, 1'b0, 1'b0);
    checkSize("size_wrAA", 1);
    pipe("wr34", 1'b0, 1'b1, 4'h0, 8'h34, 1'b0, 1'b0);
    checkSize("size_wr34", 0);

    pipe("add12", 1'b1, 1'b0, 4'h3, 8'h12, 1'b0, 1'b0);
    pipe("add12dup", 1'b1, 1'b0, 4'h3, 8'h12, 1'b0, !SCRUB_EN);
    checkSize("size_add12", 1);

`ifdef PLC_SCRUB_EN
    applyStimulus("scrub1", 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 8'h12, 1'b0);
    idle("issue1", 1'b0, 1'b0);
    idle("wait1_perr", 1'b1, 1'b1);
    checkSize("size_kept", 1);
    applyStimulus("scrub2", 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 8'h12, 1'b0);
    pipe("issue2_pipe40", 1'b0, 1'b0, 4'h0, 8'h40, 1'b0, 1'b0);
    pipe("wait2_pipe40", 1'b0, 1'b0, 4'h0, 8'h40, 1'b0, 1'b0);
    checkSize("size_false_alarm", 0);
    idle("idle_empty", 1'b0, 1'b0);

    pipe("add77", 1'b1, 1'b0, 4'h2, 8'h77, 1'b0, 1'b0);
    applyStimulus("scrub3", 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h2, 8'h77, 1'b0);
    applyStimulus("issue3_wr77", 1'b0, 1'b1, 1'b0, 4'h2, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    idle("wait3_discard", 1'b1, 1'b0);
    checkSize("size_discard", 0);

    pipe("add66", 1'b1, 1'b0, 4'h4, 8'h66, 1'b0, 1'b0);
    applyStimulus("scrub4", 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h4, 8'h66, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.re",   32'(read_enable_out), 32'd0);
    checkOutput("midrst.addr", 32'(addr_out),        32'd0);
    checkSize("midrst.size", 0);
    @(negedge clk);
    rst_n = 1'b1;
    held_addr = '0;
    held_way  = '0;
    idle("post_rst_perr", 1'b1, 1'b0);
`else
    idle("hold1", 1'b0, 1'b0);
    checkSize("size_noscrub", 1);
    applyStimulus("wr12", 1'b0, 1'b1, 1'b0, 4'h3, 8'h12, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    checkSize("size_wr12", 0);
`endif

    // Fill to capacity, overflow, repeat on a full list, then drain with compaction.
    for (int i = 0; i < 16; i++)
      pipe($sformatf("fill%0d", i), 1'b1, 1'b0, 4'(i), 8'(8'hB0 + i), 1'b0, 1'b0);
    checkSize("size_full", 16);
    pipe("add17", 1'b1, 1'b0, 4'h0, 8'hC0, 1'b0, 1'b1);
    checkSize("size_overflow", 16);
    pipe("dup_full", 1'b1, 1'b0, 4'h5, 8'hB5, 1'b0, !SCRUB_EN);
    pipe("wrB5", 1'b0, 1'b1, 4'h5, 8'hB5, 1'b0, 1'b0);
    checkSize("size_wrB5", 15);
    checkOutput("list4_compact", 32'(dut.PLC_List.list[4]), 32'h4B4);
    checkOutput("list5_compact", 32'(dut.PLC_List.list[5]), 32'h6B6);
    for (int i = 0; i < 16; i++)
      if (i != 5) pipe($sformatf("drain%0d", i), 1'b0, 1'b1, 4'(i), 8'(8'hB0 + i), 1'b0, 1'b0);
    checkSize("size_drained", 0);

    pipe("addwr20", 1'b1, 1'b1, 4'h1, 8'h20, 1'b0, 1'b0);
    checkSize("size_addwr20", 0);
    pipe("add20", 1'b1, 1'b0, 4'h1, 8'h20, 1'b0, 1'b0);
    checkSize("size_add20", 1);
    pipe("addwr20b", 1'b1, 1'b1, 4'h1, 8'h20, 1'b0, 1'b0);
    checkSize("size_addwr20b", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
